// File: rtl/fpu_int2float_seq_pkg.sv
// Shared FPU definitions: word type and FCSR rounding-mode encoding.
package fpu_int2float_seq_pkg;

  typedef logic [31:0] Word_t;

  // FCSR RM field; also used by the float-to-int converters.
  typedef enum logic [1:0] {
    RmRn = 2'd0,
    RmRz = 2'd1,
    RmRp = 2'd2,
    RmRm = 2'd3
  } fpu_rmode_t;

  // Biased exponent of 2^31, the value held when mag[31] is the leading one.
  localparam logic [7:0] ExpInit = 8'd158;

endpackage

// File: rtl/fpu_round_single.sv
// Combinational rounding of a normalized 32-bit magnitude to an IEEE-754 single.
module fpu_round_single
  import fpu_int2float_seq_pkg::*;
(
  input  logic        sign_i,
  input  logic [7:0]  exp_i,
  input  logic [31:0] mag_i,
  input  logic [1:0]  rm_i,
  output logic [31:0] result_o,
  output logic        inexact_o
);

  logic [22:0] mant;
  logic        guard;
  logic        sticky;
  logic        round_up;
  logic [23:0] mant_inc;
  logic [7:0]  exp_rnd;
  logic        is_zero;

  always_comb begin
    mant     = mag_i[30:8];
    guard    = mag_i[7];
    sticky   = |mag_i[6:0];
    is_zero  = ~|mag_i;
    round_up = 1'b0;
    unique case (fpu_rmode_t'(rm_i))
      RmRn: round_up = guard & (sticky | mant[0]);
      RmRz: round_up = 1'b0;
      RmRp: round_up = ~sign_i & (guard | sticky);
      RmRm: round_up = sign_i & (guard | sticky);
    endcase
    mant_inc = {1'b0, mant} + {23'd0, round_up};
    // Mantissa carry-out renormalizes into the exponent; exp never exceeds 158 here.
    exp_rnd  = exp_i + {7'd0, mant_inc[23]};
    if (is_zero) begin
      result_o  = 32'h0;
      inexact_o = 1'b0;
    end else begin
      result_o  = {sign_i, exp_rnd, mant_inc[22:0]};
      inexact_o = guard | sticky;
    end
  end

endmodule

// File: rtl/fpu_int2float_seq.sv
// Multicycle signed word to single-precision converter (cvt.s.w) with start/done handshake.
module fpu_int2float_seq
  import fpu_int2float_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        flush,
  input  logic [31:0] operand,
  input  logic [1:0]  rmode,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        inexact
);

  typedef enum logic [1:0] {StIdle, StNorm, StRound} state_e;

  state_e      state_q, state_d;
  logic        sign_q, sign_d;
  logic [31:0] mag_q, mag_d;
  logic [7:0]  exp_q, exp_d;
  logic [1:0]  rm_q, rm_d;
  logic        done_q, done_d;
  logic [31:0] result_q, result_d;
  logic        inexact_q, inexact_d;

  logic [31:0] rnd_result;
  logic        rnd_inexact;

  fpu_round_single u_round (
    .sign_i    (sign_q),
    .exp_i     (exp_q),
    .mag_i     (mag_q),
    .rm_i      (rm_q),
    .result_o  (rnd_result),
    .inexact_o (rnd_inexact)
  );

  always_comb begin
    state_d   = state_q;
    sign_d    = sign_q;
    mag_d     = mag_q;
    exp_d     = exp_q;
    rm_d      = rm_q;
    done_d    = 1'b0;
    result_d  = result_q;
    inexact_d = inexact_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          sign_d  = operand[31];
          // Negating 0x80000000 wraps to 0x80000000, which is exactly 2^31 unsigned.
          mag_d   = operand[31] ? (~operand + 32'd1) : operand;
          rm_d    = rmode;
          exp_d   = ExpInit;
          state_d = StNorm;
        end
      end
      StNorm: begin
        if (mag_q == 32'd0 || mag_q[31]) begin
          state_d = StRound;
        end else if (mag_q[31:24] == 8'd0) begin
          mag_d = mag_q << 8;
          exp_d = exp_q - 8'd8;
        end else begin
          mag_d = mag_q << 1;
          exp_d = exp_q - 8'd1;
        end
      end
      StRound: begin
        result_d  = rnd_result;
        inexact_d = rnd_inexact;
        done_d    = 1'b1;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (flush) begin
      state_d   = StIdle;
      done_d    = 1'b0;
      result_d  = result_q;
      inexact_d = inexact_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      sign_q    <= 1'b0;
      mag_q     <= 32'd0;
      exp_q     <= 8'd0;
      rm_q      <= 2'd0;
      done_q    <= 1'b0;
      result_q  <= 32'd0;
      inexact_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sign_q    <= sign_d;
      mag_q     <= mag_d;
      exp_q     <= exp_d;
      rm_q      <= rm_d;
      done_q    <= done_d;
      result_q  <= result_d;
      inexact_q <= inexact_d;
    end
  end

  assign busy    = (state_q != StIdle);
  assign done    = done_q;
  assign result  = result_q;
  assign inexact = inexact_q;

endmodule
